uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver. Captures each completed byte (rx_data qualified by rx_ready) into a synchronous FIFO and presents it to the host over a valid/ready interface. Also tracks framing errors reported by the receiver and FIFO overflow. Decouples the bit-rate receiver from a host that may stall.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo_if.sv | 20 ++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and a pointer-width helper used by the receive and transmit buffers.
package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int UART_RX_FIFO_DEPTH_DEF = 16;

  // Number of address bits needed to index 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side valid/ready byte stream presented by the UART receive buffer.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO: combinational head read, simultaneous push/pop,
// and a push into a full FIFO is accepted only when a pop frees an entry that cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_RX_FIFO_DEPTH_DEF,
  parameter  int DATA_W = UART_DATA_W,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              wr_en
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rd_en = pop & ~empty;
  // A pop in the same cycle makes room, so a full FIFO still accepts the push.
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  // Memory is never cleared, so the head is forced to zero while empty.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: edge-detected byte capture, overflow and framing-error tracking.
// Optional flow-control output rts_n is built when UART_RX_FIFO_RTS_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_RX_FIFO_DEPTH_DEF,
  parameter  int DATA_W = UART_DATA_W,
`ifdef UART_RX_FIFO_RTS_EN
  parameter  int AFULL  = 12,
`endif
  localparam int CNT_W  = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  uart_rx_fifo_if.master    host,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        frame_err_cnt,
  input  logic              clr_flags
`ifdef UART_RX_FIFO_RTS_EN
  ,
  output logic              rts_n
`endif
);

  logic              rx_ready_q;
  logic              rx_error_q;
  logic              overflow_q, overflow_d;
  logic [7:0]        frame_err_cnt_q, frame_err_cnt_d;
  logic              push, pop, err_evt, drop;
  logic              wr_en, empty;
  logic [DATA_W-1:0] rd_data;

  assign push    = rx_ready & ~rx_ready_q;
  assign err_evt = rx_error & ~rx_error_q;
  assign pop     = ~empty & host.out_ready;
  assign drop    = push & ~wr_en;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (rx_data),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .wr_en   (wr_en)
  );

  // A fresh event in the clearing cycle survives the clear.
  always_comb begin
    overflow_d      = overflow_q | drop;
    frame_err_cnt_d = frame_err_cnt_q;
    if (err_evt && frame_err_cnt_q != 8'hFF) frame_err_cnt_d = frame_err_cnt_q + 8'd1;
    if (clr_flags) begin
      overflow_d      = drop;
      frame_err_cnt_d = {7'd0, err_evt};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready_q      <= 1'b0;
      rx_error_q      <= 1'b0;
      overflow_q      <= 1'b0;
      frame_err_cnt_q <= '0;
    end else begin
      rx_ready_q      <= rx_ready;
      rx_error_q      <= rx_error;
      overflow_q      <= overflow_d;
      frame_err_cnt_q <= frame_err_cnt_d;
    end
  end

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL);

  logic [CNT_W-1:0] count_next;
  logic             rts_n_q, rts_n_d;

  // Track the next occupancy so rts_n changes in the same cycle as count.
  always_comb begin
    count_next = count + CNT_W'(wr_en) - CNT_W'(pop);
    rts_n_d    = (count_next >= AFULL_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rts_n_q <= 1'b0;
    else          rts_n_q <= rts_n_d;
  end

  assign rts_n = rts_n_q;
`endif

  assign host.out_data  = rd_data;
  assign host.out_valid = ~empty;
  assign overflow       = overflow_q;
  assign frame_err_cnt  = frame_err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus scoreboard-backed corner sequences.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_ready = 1'b0;
  logic             rx_error = 1'b0;
  logic             clr_flags = 1'b0;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;
  logic [7:0]       frame_err_cnt;
`ifdef UART_RX_FIFO_RTS_EN
  logic             rts_n;
`endif

  uart_rx_fifo_if #(.DATA_W(8)) bus ();

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
`ifdef UART_RX_FIFO_RTS_EN
    .AFULL  (AFULL),
`endif
    .DATA_W (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_error      (rx_error),
    .host          (bus),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .frame_err_cnt (frame_err_cnt),
    .clr_flags     (clr_flags)
`ifdef UART_RX_FIFO_RTS_EN
    ,
    .rts_n         (rts_n)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       err;
    logic       ordy;
    logic       clr;
    int         e_cnt;
    logic       e_valid;
    int         e_fec;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic       m_rdy_q, m_err_q, m_ovf;
  int         m_fec;
  logic [7:0] last_pop;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic [7:0] data, input logic err,
                              input logic ordy, input logic clr, input int e_cnt,
                              input logic e_valid, input int e_fec);
    vec_t v;
    v.rdy = rdy; v.data = data; v.err = err; v.ordy = ordy; v.clr = clr;
    v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_fec = e_fec;
    return v;
  endfunction

  // One clock: model the edge from inputs held since the last step, then compare state.
  task automatic tick();
    logic full_pre, popping, pushing, drop, evt;
    @(negedge clk);
    full_pre = (exp_q.size() == DEPTH);
    popping  = bus.out_ready && (exp_q.size() != 0);
    if (popping) begin
      chk("pop_data", bus.out_data, exp_q[0]);
      last_pop = exp_q.pop_front();
    end
    pushing = rx_ready && !m_rdy_q;
    drop    = pushing && full_pre && !popping;
    if (pushing && !drop) exp_q.push_back(rx_data);
    evt = rx_error && !m_err_q;
    if (clr_flags) begin
      m_ovf = drop;
      m_fec = evt ? 1 : 0;
    end else begin
      m_ovf = m_ovf | drop;
      if (evt && m_fec != 255) m_fec++;
    end
    m_rdy_q = rx_ready;
    m_err_q = rx_error;
    @(posedge clk);
    #1;
    chk("count", count, exp_q.size());
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    chk("full", full, exp_q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("frame_err_cnt", frame_err_cnt, m_fec);
`ifdef UART_RX_FIFO_RTS_EN
    chk("rts_n", rts_n, exp_q.size() >= AFULL);
`endif
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_rdy_q = 1'b0;
    m_err_q = 1'b0;
    m_ovf   = 1'b0;
    m_fec   = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_ready = 1'b0; rx_error = 1'b0; clr_flags = 1'b0; rx_data = '0;
    bus.out_ready = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fec", frame_err_cnt, 0);
    chk("rst_out_data", bus.out_data, 0);
`ifdef UART_RX_FIFO_RTS_EN
    chk("rst_rts_n", rts_n, 0);
`endif
    reset_n = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b0;
    clear_model();
    last_pop = '0;

    // Single push/pop, held rx_ready, framing-error edges and clr_flags priority.
    vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));

    do_reset();
    foreach (vecs[i]) begin
      rx_ready      = vecs[i].rdy;
      rx_data       = vecs[i].data;
      rx_error      = vecs[i].err;
      bus.out_ready = vecs[i].ordy;
      clr_flags     = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_fec", i), frame_err_cnt, vecs[i].e_fec);
    end
    rx_ready = 1'b0; rx_error = 1'b0; bus.out_ready = 1'b0; clr_flags = 1'b0;

    // Overflow: 17 pushes into 16 entries, then drain 0x00..0x0F.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i));
      if (i == 15) begin
        chk("full_after_16", full, 1);
        chk("ovf_after_16", overflow, 0);
      end
    end
    chk("ovf_after_17", overflow, 1);
    chk("count_after_17", count, 16);
    bus.out_ready = 1'b1;
    repeat (16) tick();
    bus.out_ready = 1'b0;
    chk("drain_last", last_pop, 8'h0F);
    chk("drain_empty", bus.out_valid, 0);

    // Full FIFO: push and pop in the same cycle.
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    rx_data = 8'h55; rx_ready = 1'b1; bus.out_ready = 1'b1;
    tick();
    rx_ready = 1'b0; bus.out_ready = 1'b0;
    chk("fullpop_count", count, 16);
    chk("fullpop_ovf", overflow, 0);
    bus.out_ready = 1'b1;
    repeat (16) tick();
    bus.out_ready = 1'b0;
    chk("fullpop_last", last_pop, 8'h55);

    // Frame error counter saturation and clear.
    do_reset();
    repeat (260) begin
      rx_error = 1'b1; tick();
      rx_error = 1'b0; tick();
    end
    chk("fec_saturate", frame_err_cnt, 255);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("fec_cleared", frame_err_cnt, 0);

`ifdef UART_RX_FIFO_RTS_EN
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push_byte(8'(8'h40 + i));
      if (i == 10) chk("rts_at_11", rts_n, 0);
    end
    chk("rts_at_12", rts_n, 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    chk("rts_after_pop", rts_n, 0);
`endif

    // Asynchronous reset in the middle of a burst.
    push_byte(8'h90);
    push_byte(8'h91);
    push_byte(8'h92);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", bus.out_valid, 0);
`ifdef UART_RX_FIFO_RTS_EN
    chk("midrst_rts_n", rts_n, 0);
`endif
    clear_model();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_byte(8'h77);
    chk("midrst_first_data", bus.out_data, 8'h77);
    chk("midrst_first_count", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
